// File: rtl/uart_frame_collector.sv
// -----------------------------------------------------------------------------
// uart_frame_collector
//
// Sits behind uart_rx. It waits for a sync byte, captures a fixed-length
// payload of packed pixels, optionally checks a trailing mod-256 checksum, and
// then holds the frame for the OCR datapath. The datapath reads elements
// through a registered random-access port. A consume pulse re-arms the
// collector, so no reset is needed between images. Inter-byte timeouts and bad
// checksums drop the partial frame and return to hunting for sync.
//
// Ports
//   i_Clock        system clock
//   i_Rst_L        asynchronous, active-low reset
//   i_RX_DV        one-cycle byte-valid strobe from uart_rx
//   i_RX_Byte      received byte, valid with i_RX_DV
//   i_Consume      one-cycle pulse: datapath is done with the frame
//   i_Rd_Addr      element index to read
//   o_Rd_Data      element at i_Rd_Addr, zero-extended, one-cycle latency
//   o_Frame_Ready  level: a complete, verified frame is held
//   o_Busy         level: reception in progress (RECV or CHECK)
//   o_Frame_Err    pulse: checksum mismatch
//   o_Timeout      pulse: inter-byte timeout aborted the frame
//   o_Overrun      pulse: a byte arrived while READY and was dropped
//   o_Byte_Count   payload bytes received in the current frame
//   o_State        IDLE=0, RECV=1, CHECK=2, READY=3
// -----------------------------------------------------------------------------
module uart_frame_collector #(
    parameter int          NUM_ELEMS     = 784,
    parameter int          BITS_PER_ELEM = 1,
    parameter int          ELEM_WIDTH    = 32,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter bit          USE_CHECKSUM  = 1'b1,
    parameter int          TIMEOUT_CLKS  = 520900,
    localparam int PAYLOAD_BYTES = (NUM_ELEMS * BITS_PER_ELEM + 7) / 8,
    localparam int ADDR_W        = $clog2(NUM_ELEMS),
    localparam int CNT_W         = $clog2(PAYLOAD_BYTES + 1)
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_L,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_Consume,
    input  logic [ADDR_W-1:0]     i_Rd_Addr,
    output logic [ELEM_WIDTH-1:0] o_Rd_Data,
    output logic                  o_Frame_Ready,
    output logic                  o_Busy,
    output logic                  o_Frame_Err,
    output logic                  o_Timeout,
    output logic                  o_Overrun,
    output logic [CNT_W-1:0]      o_Byte_Count,
    output logic [1:0]            o_State
);

    localparam int         BYTE_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int         TO_W      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int         OFF_W     = ADDR_W + 4;
    localparam logic [7:0] ELEM_MASK = 8'((1 << BITS_PER_ELEM) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        READY = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [7:0]            sum_q, sum_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  err_d, timeout_d, overrun_d, wr_en;
    logic                  timeout_hit;
    logic                  frame_ready_q, busy_q, err_q, timeout_q, overrun_q;
    logic [ELEM_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [7:0]            store_q [PAYLOAD_BYTES];
    logic [OFF_W-1:0]      bit_off;
    logic [7:0]            sel_byte;
    logic [7:0]            elem;

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would infer a latch.
        state_d   = state_q;
        count_d   = count_q;
        sum_d     = sum_q;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        wr_en     = 1'b0;

        // A disabled timeout never fires; the counter just wraps harmlessly.
        timeout_hit = (TIMEOUT_CLKS != 0) && (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));

        // The gap counter restarts on every byte and only runs mid-frame.
        if (i_RX_DV || state_q == IDLE || state_q == READY) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_RX_DV && i_RX_Byte == SYNC_BYTE) begin
                    state_d = RECV;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            RECV: begin
                // A byte arriving on the timeout cycle wins over the timeout.
                if (i_RX_DV) begin
                    wr_en   = 1'b1;
                    sum_d   = sum_q + i_RX_Byte;
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
                        state_d = USE_CHECKSUM ? CHECK : READY;
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            CHECK: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == sum_q) begin
                        state_d = READY;
                    end else begin
                        state_d = IDLE;
                        count_d = '0;
                        err_d   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            READY: begin
                // Any byte here is dropped, even one that coincides with
                // consume; it is never examined as a sync byte.
                overrun_d = i_RX_DV;
                if (i_Consume) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Element extraction: elements never straddle a byte, so one byte select
    // plus a shift and mask is enough.
    always_comb begin
        bit_off   = OFF_W'(i_Rd_Addr) * OFF_W'(BITS_PER_ELEM);
        sel_byte  = store_q[BYTE_W'(bit_off >> 3)] >> bit_off[2:0];
        elem      = sel_byte & ELEM_MASK;
        rd_data_d = '0;
        if (frame_ready_q && (int'(i_Rd_Addr) < NUM_ELEMS)) begin
            rd_data_d = ELEM_WIDTH'(elem);
        end
    end

    // Control registers. Flags are driven from the next state so they change
    // on the same edge as o_State.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q       <= IDLE;
            count_q       <= '0;
            sum_q         <= '0;
            to_cnt_q      <= '0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            sum_q         <= sum_d;
            to_cnt_q      <= to_cnt_d;
            frame_ready_q <= (state_d == READY);
            busy_q        <= (state_d == RECV) || (state_d == CHECK);
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // NOTE: the payload store has no reset; reads are gated by the ready flag,
    // so stale contents are never visible and the array can map to RAM.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            store_q[BYTE_W'(count_q)] <= i_RX_Byte;
        end
    end

    assign o_Rd_Data     = rd_data_q;
    assign o_Frame_Ready = frame_ready_q;
    assign o_Busy        = busy_q;
    assign o_Frame_Err   = err_q;
    assign o_Timeout     = timeout_q;
    assign o_Overrun     = overrun_q;
    assign o_Byte_Count  = count_q;
    assign o_State       = state_q;

endmodule

// File: tb/tb_uart_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_collector
//
// Two collectors share one clock:
//   dut_a: 16 x 1-bit elements, checksum on, 50-clock timeout
//   dut_b:  4 x 4-bit elements, no checksum
// Stimulus pushes expected read data and expected event pulses (kind plus the
// cycle they must appear in) into queues; a negedge monitor pops and compares
// whenever the DUT presents a read result or pulses an event flag.
// -----------------------------------------------------------------------------
module tb_uart_frame_collector;

    localparam int EV_ERR = 1;
    localparam int EV_TO  = 2;
    localparam int EV_OVR = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- dut_a ----------------
    logic        rst_a, dv_a, consume_a;
    logic [7:0]  byte_a;
    logic [3:0]  addr_a;
    logic [31:0] rd_a;
    logic        ready_a, busy_a, err_a, to_a, ovr_a;
    logic [1:0]  cnt_a, state_a;

    uart_frame_collector #(
        .NUM_ELEMS(16), .BITS_PER_ELEM(1), .ELEM_WIDTH(32),
        .SYNC_BYTE(8'hA5), .USE_CHECKSUM(1'b1), .TIMEOUT_CLKS(50)
    ) dut_a (
        .i_Clock(clk), .i_Rst_L(rst_a), .i_RX_DV(dv_a), .i_RX_Byte(byte_a),
        .i_Consume(consume_a), .i_Rd_Addr(addr_a), .o_Rd_Data(rd_a),
        .o_Frame_Ready(ready_a), .o_Busy(busy_a), .o_Frame_Err(err_a),
        .o_Timeout(to_a), .o_Overrun(ovr_a), .o_Byte_Count(cnt_a),
        .o_State(state_a)
    );

    // ---------------- dut_b ----------------
    logic        rst_b, dv_b, consume_b;
    logic [7:0]  byte_b;
    logic [1:0]  addr_b;
    logic [31:0] rd_b;
    logic        ready_b, busy_b, err_b, to_b, ovr_b;
    logic [1:0]  cnt_b, state_b;

    uart_frame_collector #(
        .NUM_ELEMS(4), .BITS_PER_ELEM(4), .ELEM_WIDTH(32),
        .SYNC_BYTE(8'hA5), .USE_CHECKSUM(1'b0), .TIMEOUT_CLKS(1000)
    ) dut_b (
        .i_Clock(clk), .i_Rst_L(rst_b), .i_RX_DV(dv_b), .i_RX_Byte(byte_b),
        .i_Consume(consume_b), .i_Rd_Addr(addr_b), .o_Rd_Data(rd_b),
        .o_Frame_Ready(ready_b), .o_Busy(busy_b), .o_Frame_Err(err_b),
        .o_Timeout(to_b), .o_Overrun(ovr_b), .o_Byte_Count(cnt_b),
        .o_State(state_b)
    );

    // ---------------- scoreboard ----------------
    ev_t         ev_q[$];
    logic [31:0] rdq_a[$];
    logic [31:0] rdq_b[$];
    logic        rdr_a = 1'b0, rdr_b = 1'b0;
    logic        rdp_a = 1'b0, rdp_b = 1'b0;

    always @(posedge clk) begin
        rdp_a <= rdr_a;
        rdp_b <= rdr_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic ev_seen(input int kind);
        checks++;
        if (ev_q.size() > 0 && ev_q[0].kind == kind && ev_q[0].cyc == cyc) begin
            passes++;
            void'(ev_q.pop_front());
        end else begin
            if (ev_q.size() > 0) begin
                $display("FAIL event: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                         kind, cyc, ev_q[0].kind, ev_q[0].cyc);
                void'(ev_q.pop_front());
            end else begin
                $display("FAIL event: got unexpected kind %0d at cycle %0d expected none", kind, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_a) begin
            if (err_a) ev_seen(EV_ERR);
            if (to_a)  ev_seen(EV_TO);
            if (ovr_a) ev_seen(EV_OVR);
        end
        if (rst_b && (err_b || to_b || ovr_b))
            check("b_pulses", {29'd0, err_b, to_b, ovr_b}, 32'd0);
        if (rdp_a) begin
            if (rdq_a.size() > 0) check("rd_a", rd_a, rdq_a.pop_front());
            else check("rd_a_unexpected", 32'd1, 32'd0);
        end
        if (rdp_b) begin
            if (rdq_b.size() > 0) check("rd_b", rd_b, rdq_b.pop_front());
            else check("rd_b_unexpected", 32'd1, 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_a(input logic [7:0] b);
        dv_a = 1'b1; byte_a = b;
        tick();
        dv_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        dv_b = 1'b1; byte_b = b;
        tick();
        dv_b = 1'b0;
    endtask

    // Expect an event pulse visible in the cycle right after the edge just taken.
    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        ev_q.push_back(e);
    endtask

    task automatic read_a(input logic [3:0] a, input logic [31:0] exp);
        addr_a = a; rdr_a = 1'b1; rdq_a.push_back(exp);
        tick();
        rdr_a = 1'b0;
    endtask

    task automatic read_b(input logic [1:0] a, input logic [31:0] exp);
        addr_b = a; rdr_b = 1'b1; rdq_b.push_back(exp);
        tick();
        rdr_b = 1'b0;
    endtask

    task automatic consume_a_pulse();
        consume_a = 1'b1;
        tick();
        consume_a = 1'b0;
    endtask

    task automatic good_frame_a();
        send_a(8'hA5);
        send_a(8'h81);
        send_a(8'h3C);
        send_a(8'hBD);
    endtask

    // Watchdog: the run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_a = 1'b0; dv_a = 1'b0; byte_a = 8'h00; consume_a = 1'b0; addr_a = '0;
        rst_b = 1'b0; dv_b = 1'b0; byte_b = 8'h00; consume_b = 1'b0; addr_b = '0;
        #12;
        check("rst_state",  {30'd0, state_a}, 32'd0);
        check("rst_ready",  {31'd0, ready_a}, 32'd0);
        check("rst_busy",   {31'd0, busy_a},  32'd0);
        check("rst_rd",     rd_a,             32'd0);
        check("rst_cnt",    {30'd0, cnt_a},   32'd0);
        check("rst_pulses", {29'd0, err_a, to_a, ovr_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        tick();

        // Valid frame: 0x81 + 0x3C = 0xBD.
        send_a(8'hA5);
        check("a_recv_state", {30'd0, state_a}, 32'd1);
        check("a_recv_busy",  {31'd0, busy_a},  32'd1);
        send_a(8'h81);
        send_a(8'h3C);
        check("a_check_state", {30'd0, state_a}, 32'd2);
        check("a_check_cnt",   {30'd0, cnt_a},   32'd2);
        send_a(8'hBD);
        check("a_ready_state", {30'd0, state_a}, 32'd3);
        check("a_ready_flag",  {31'd0, ready_a}, 32'd1);
        check("a_ready_busy",  {31'd0, busy_a},  32'd0);
        check("a_ready_cnt",   {30'd0, cnt_a},   32'd2);
        read_a(4'd0, 32'd1);
        read_a(4'd7, 32'd1);
        read_a(4'd1, 32'd0);
        read_a(4'd10, 32'd1);
        read_a(4'd12, 32'd1);
        read_a(4'd15, 32'd0);
        consume_a_pulse();
        check("a_consume_ready", {31'd0, ready_a}, 32'd0);
        check("a_consume_state", {30'd0, state_a}, 32'd0);
        check("a_consume_cnt",   {30'd0, cnt_a},   32'd0);
        read_a(4'd0, 32'd0);

        // Bad checksum.
        send_a(8'hA5);
        send_a(8'h81);
        send_a(8'h3C);
        send_a(8'hBC);
        expect_ev(EV_ERR, cyc);
        check("a_err_state", {30'd0, state_a}, 32'd0);
        idle(2);
        check("a_err_ready", {31'd0, ready_a}, 32'd0);
        read_a(4'd0, 32'd0);
        read_a(4'd7, 32'd0);

        // Noise before sync, then a good frame, then overruns.
        send_a(8'h00);
        send_a(8'hFF);
        check("a_noise_state", {30'd0, state_a}, 32'd0);
        good_frame_a();
        check("a_noise_ready", {31'd0, ready_a}, 32'd1);
        send_a(8'h55);
        expect_ev(EV_OVR, cyc);
        send_a(8'hA5);
        expect_ev(EV_OVR, cyc);
        check("a_ovr_state", {30'd0, state_a}, 32'd3);
        read_a(4'd0, 32'd1);
        read_a(4'd7, 32'd1);
        read_a(4'd10, 32'd1);

        // Consume together with an A5 byte: consume wins, byte dropped.
        consume_a = 1'b1; dv_a = 1'b1; byte_a = 8'hA5;
        tick();
        consume_a = 1'b0; dv_a = 1'b0;
        expect_ev(EV_OVR, cyc);
        check("a_cons_dv_state", {30'd0, state_a}, 32'd0);
        idle(2);
        check("a_cons_dv_idle", {30'd0, state_a}, 32'd0);
        // Second frame: 0xF0 + 0x0F = 0xFF.
        send_a(8'hA5);
        send_a(8'hF0);
        send_a(8'h0F);
        send_a(8'hFF);
        check("a_f2_ready", {31'd0, ready_a}, 32'd1);
        read_a(4'd0, 32'd0);
        read_a(4'd4, 32'd1);
        read_a(4'd8, 32'd1);
        read_a(4'd15, 32'd0);
        consume_a_pulse();

        // Timeout: byte edge is gap reference; pulse after 50 idle edges.
        send_a(8'hA5);
        send_a(8'h12);
        expect_ev(EV_TO, cyc + 50);
        idle(60);
        check("a_to_state", {30'd0, state_a}, 32'd0);
        check("a_to_cnt",   {30'd0, cnt_a},   32'd0);
        check("a_to_busy",  {31'd0, busy_a},  32'd0);
        good_frame_a();
        check("a_after_to_ready", {31'd0, ready_a}, 32'd1);
        read_a(4'd12, 32'd1);
        consume_a_pulse();

        // dut_b: 4-bit elements, no checksum.
        send_b(8'hA5);
        send_b(8'h21);
        send_b(8'h43);
        check("b_ready_state", {30'd0, state_b}, 32'd3);
        check("b_ready_cnt",   {30'd0, cnt_b},   32'd2);
        read_b(2'd0, 32'd1);
        read_b(2'd1, 32'd2);
        read_b(2'd2, 32'd3);
        read_b(2'd3, 32'd4);
        consume_b = 1'b1;
        tick();
        consume_b = 1'b0;
        send_b(8'hA5);
        send_b(8'h21);
        check("b_mid_busy", {31'd0, busy_b}, 32'd1);
        check("b_mid_cnt",  {30'd0, cnt_b},  32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("b_rst_state", {30'd0, state_b}, 32'd0);
        check("b_rst_busy",  {31'd0, busy_b},  32'd0);
        check("b_rst_cnt",   {30'd0, cnt_b},   32'd0);
        check("b_rst_ready", {31'd0, ready_b}, 32'd0);
        check("b_rst_rd",    rd_b,             32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        send_b(8'hA5);
        send_b(8'h21);
        send_b(8'h43);
        read_b(2'd1, 32'd2);
        read_b(2'd3, 32'd4);
        idle(3);

        // Every expectation must have been met.
        check("ev_q_drained",  ev_q.size(),  32'd0);
        check("rdq_a_drained", rdq_a.size(), 32'd0);
        check("rdq_b_drained", rdq_b.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
